// File: rtl/line_window_gen_if.sv
// line_window_gen_if: raster-order pixel stream handshake into line_window_gen
//   pixel_in     8-bit grayscale pixel, raster order (top-left first)
//   pixel_valid  pixel_in is valid this cycle
//   pixel_ready  receiver accepts a pixel this cycle
//   master = image memory reader side, slave = line_window_gen
interface line_window_gen_if;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       pixel_ready;
    modport master (output pixel_in, pixel_valid, input pixel_ready);
    modport slave  (input pixel_in, pixel_valid, output pixel_ready);
endinterface

// File: rtl/line_window_gen.sv
// line_window_gen: buffers two image lines and emits a registered 3x3 pixel window per accepted pixel
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   start               one-cycle frame start pulse, honoured only in IDLE
//   pix (slave)         pixel_in / pixel_valid / pixel_ready stream
//   pixel_00..pixel_22  registered window, pixel_rc = row r column c, pixel_22 newest
//   window_valid        one-cycle strobe: window outputs hold a complete new window
//   frame_done          one-cycle pulse after the last pixel of the frame is accepted
//   busy                high while streaming a frame
//   win_count           window strobes in current/last frame (only with LINE_WINDOW_COUNT_EN)
module line_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    line_window_gen_if.slave pix,
    output logic [7:0]       pixel_00,
    output logic [7:0]       pixel_01,
    output logic [7:0]       pixel_02,
    output logic [7:0]       pixel_10,
    output logic [7:0]       pixel_11,
    output logic [7:0]       pixel_12,
    output logic [7:0]       pixel_20,
    output logic [7:0]       pixel_21,
    output logic [7:0]       pixel_22,
    output logic             window_valid,
    output logic             frame_done,
    output logic             busy
`ifdef LINE_WINDOW_COUNT_EN
    ,
    output logic [15:0]      win_count
`endif
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [7:0]    lb0 [IMG_WIDTH];
    logic [7:0]    lb1 [IMG_WIDTH];
    logic          acc, eol, eof, go;

    assign go             = state == IDLE && start;
    assign acc            = pix.pixel_valid && state == RUN;
    assign eol            = c == CW'(IMG_WIDTH - 1);
    assign eof            = eol && r == RW'(IMG_HEIGHT - 1);
    assign pix.pixel_ready = state == RUN;
    assign busy           = state == RUN;
    assign frame_done     = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            c     <= '0;
            r     <= '0;
        end else begin
            state <= go ? RUN : (acc && eof) ? DONE : state == DONE ? IDLE : state;
            if (go) begin
                c <= '0;
                r <= '0;
            end else if (acc) begin
                c <= eol ? '0 : c + 1'b1;
                r <= eol ? r + 1'b1 : r;
            end
        end
    end

    // Line buffers are not reset; lb1[c]/lb0[c] are read before this edge's write
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[c] <= lb0[c];
            lb0[c] <= pix.pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {pixel_00, pixel_01, pixel_02, pixel_10, pixel_11, pixel_12,
             pixel_20, pixel_21, pixel_22} <= '0;
            window_valid <= 1'b0;
        end else begin
            // Windows straddling a line wrap (c<2) or lacking two rows above (r<2) are incomplete
            window_valid <= acc && r >= RW'(2) && c >= CW'(2);
            if (acc) begin
                pixel_00 <= pixel_01;
                pixel_01 <= pixel_02;
                pixel_02 <= lb1[c];
                pixel_10 <= pixel_11;
                pixel_11 <= pixel_12;
                pixel_12 <= lb0[c];
                pixel_20 <= pixel_21;
                pixel_21 <= pixel_22;
                pixel_22 <= pix.pixel_in;
            end
        end
    end

`ifdef LINE_WINDOW_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            win_count <= '0;
        else if (go)
            win_count <= '0;
        else if (window_valid && win_count != 16'hFFFF)
            win_count <= win_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: scoreboard bench for line_window_gen on a 4x4 image
`timescale 1ns/1ps
module tb_line_window_gen;
    localparam int W = 4, H = 4;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic       window_valid, frame_done, busy;
`ifdef LINE_WINDOW_COUNT_EN
    logic [15:0] win_count;
`endif
    line_window_gen_if pix();

    line_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .pix(pix),
        .pixel_00(p00), .pixel_01(p01), .pixel_02(p02),
        .pixel_10(p10), .pixel_11(p11), .pixel_12(p12),
        .pixel_20(p20), .pixel_21(p21), .pixel_22(p22),
        .window_valid(window_valid), .frame_done(frame_done), .busy(busy)
`ifdef LINE_WINDOW_COUNT_EN
        , .win_count(win_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          n_win = 0, n_fd = 0;
    logic [71:0] sb [$];
    logic [71:0] win;
    assign win = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (window_valid) begin
                n_win++;
                if (sb.size() == 0) chk("unexpected_window", 72'(1), 72'(0));
                else chk("window", win, sb.pop_front());
            end
            if (frame_done) n_fd++;
        end
    end

    task automatic run_frame(input bit gaps, input bit rnd);
        logic [7:0] img [W*H];
        for (int i = 0; i < W*H; i++) img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
        n_win = 0;
        n_fd  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_run", 72'(busy), 72'(1));
`ifdef LINE_WINDOW_COUNT_EN
        chk("win_count_clr", 72'(win_count), 72'(0));
`endif
        for (int i = 0; i < W*H; i++) begin
            int r = i / W;
            int c = i % W;
            if (gaps && i > 0) begin
                pix.pixel_valid = 1'b0;
                @(posedge clk); #1;
                chk("stall_wv", 72'(window_valid), 72'(0));
            end
            pix.pixel_valid = 1'b1;
            pix.pixel_in    = img[i];
            chk("ready", 72'(pix.pixel_ready), 72'(1));
            if (r >= 2 && c >= 2)
                sb.push_back({img[i-2*W-2], img[i-2*W-1], img[i-2*W],
                              img[i-W-2],   img[i-W-1],   img[i-W],
                              img[i-2],     img[i-1],     img[i]});
            @(posedge clk); #1;
            chk("wv_latency", 72'(window_valid), 72'(r >= 2 && c >= 2));
        end
        pix.pixel_valid = 1'b0;
        chk("frame_done", 72'(frame_done), 72'(1));
        chk("busy_done", 72'(busy), 72'(0));
        @(posedge clk); #1;
        chk("frame_done_clr", 72'(frame_done), 72'(0));
        chk("busy_idle", 72'(busy), 72'(0));
        chk("ready_idle", 72'(pix.pixel_ready), 72'(0));
        chk("win_total", 72'(n_win), 72'((W-2)*(H-2)));
        chk("fd_pulses", 72'(n_fd), 72'(1));
        chk("sb_empty", 72'(sb.size()), 72'(0));
`ifdef LINE_WINDOW_COUNT_EN
        chk("win_count", 72'(win_count), 72'((W-2)*(H-2)));
`endif
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_win"}, win, 72'(0));
        chk({tag, "_wv"}, 72'(window_valid), 72'(0));
        chk({tag, "_fd"}, 72'(frame_done), 72'(0));
        chk({tag, "_ready"}, 72'(pix.pixel_ready), 72'(0));
        chk({tag, "_busy"}, 72'(busy), 72'(0));
`ifdef LINE_WINDOW_COUNT_EN
        chk({tag, "_cnt"}, 72'(win_count), 72'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pix.pixel_valid = 1'b0;
        pix.pixel_in    = 8'h00;
        #2 reset_outputs("por");
        @(posedge clk); #1 rst = 1'b1;

        // Continuous frame, then same frame with pixel_valid low every other cycle
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        // Pixels offered in IDLE must be ignored, including during the start cycle
        pix.pixel_valid = 1'b1;
        pix.pixel_in    = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_ready", 72'(pix.pixel_ready), 72'(0));
            chk("idle_wv", 72'(window_valid), 72'(0));
        end
        run_frame(1'b0, 1'b0);

        // Abort a frame after pixel 9 with an asynchronous reset
        n_win = 0;
        n_fd  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix.pixel_valid = 1'b1;
            pix.pixel_in    = 8'(i);
            @(posedge clk); #1;
        end
        pix.pixel_valid = 1'b0;
        rst = 1'b0;
        #1 reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_wv", 72'(n_win), 72'(0));
        chk("abort_no_fd", 72'(n_fd), 72'(0));
        chk("abort_wv_idle", 72'(window_valid), 72'(0));
        run_frame(1'b0, 1'b0);

        // Back-to-back frames with random pixel data
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
